// File: rtl/dsp_mac_engine.sv
// Pipelined pre-add / multiply / accumulate engine running N-sample dot-product jobs
// between a sample valid/ready stream and a result valid/ready port.
module dsp_mac_engine #(
  parameter int AW       = 18,
  parameter int BW       = 18,
  parameter int PW       = 48,
  parameter int MPIPE    = 2,
  parameter int LEN_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] len,
  input  logic             pre_en,
  input  logic             pre_sub,
  input  logic [PW-1:0]    c_init,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    a_in,
  input  logic [BW-1:0]    b_in,
  input  logic [BW-1:0]    d_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    p_out,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [LEN_W-1:0]      remaining;
  logic                  pre_en_q, pre_sub_q;
  logic signed [PW-1:0]  acc;
  logic signed [PW-1:0]  p_q;
  logic                  ovf_q;
  logic [MPIPE-1:0]      pipe_vld;
  logic signed [PW-1:0]  pipe_data [MPIPE];

  logic                  accept, flush;
  logic signed [AW-1:0]  a_s;
  logic signed [BW-1:0]  b_s, d_s;
  logic signed [BW:0]    pre;
  logic signed [AW+BW:0] prod;
  logic signed [PW-1:0]  m_ext;
  logic signed [PW:0]    sum;
  logic                  sum_ovf;
  logic signed [PW-1:0]  acc_nxt;

  assign accept = in_valid && (state == RUN);
  // Abort only acts on a running job; in IDLE it must not mask a start.
  assign flush  = abort && (state != IDLE);

  // Pre-adder is one bit wider than its operands so D +/- B can never wrap.
  assign a_s   = a_in;
  assign b_s   = b_in;
  assign d_s   = d_in;
  assign pre   = pre_en_q ? (pre_sub_q ? (BW+1)'(d_s) - (BW+1)'(b_s)
                                       : (BW+1)'(d_s) + (BW+1)'(b_s))
                          : (BW+1)'(b_s);
  assign prod  = (AW+BW+1)'(pre) * (AW+BW+1)'(a_s);
  assign m_ext = PW'(prod);

  // One guard bit: the two top bits of the sum disagree exactly on overflow.
  assign sum     = (PW+1)'(acc) + (PW+1)'(pipe_data[MPIPE-1]);
  assign sum_ovf = sum[PW] ^ sum[PW-1];
  assign acc_nxt = (sum_ovf && (SATURATE != 0))
                   ? (sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}})
                   : sum[PW-1:0];

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : RUN;
      RUN:     if (accept && remaining == LEN_W'(1)) state_nxt = DRAIN;
      DRAIN:   if (pipe_vld == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state     <= IDLE;
      remaining <= '0;
      pre_en_q  <= 1'b0;
      pre_sub_q <= 1'b0;
      acc       <= '0;
      p_q       <= '0;
      ovf_q     <= 1'b0;
      pipe_vld  <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        pipe_vld <= '0;
      end else begin
        pipe_vld[0] <= accept;
        for (int i = 1; i < MPIPE; i++) pipe_vld[i] <= pipe_vld[i-1];

        case (state)
          IDLE: if (start) begin
            pre_en_q  <= pre_en;
            pre_sub_q <= pre_sub;
            acc       <= c_init;
            ovf_q     <= 1'b0;
            remaining <= len;
            if (len == '0) p_q <= c_init;
          end
          RUN:     if (accept) remaining <= remaining - LEN_W'(1);
          DRAIN:   if (pipe_vld == '0) p_q <= acc;
          default: ;
        endcase

        if (pipe_vld[MPIPE-1]) begin
          acc <= acc_nxt;
          if (sum_ovf) ovf_q <= 1'b1;
        end
      end
    end
  end

  // NOTE: the data pipeline is deliberately not reset; pipe_vld qualifies every
  // stage, so stale contents are never accumulated.
  always_ff @(posedge CLK) begin
    pipe_data[0] <= m_ext;
    for (int i = 1; i < MPIPE; i++) pipe_data[i] <= pipe_data[i-1];
  end

  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign p_out     = p_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_engine.sv
// Scoreboard bench for dsp_mac_engine: two instances (saturating, MPIPE=2 and
// wrapping, MPIPE=3) share stimulus; an arithmetic model predicts each job result.
module tb_dsp_mac_engine;

  localparam int AW    = 18;
  localparam int BW    = 18;
  localparam int PW    = 40;
  localparam int LEN_W = 8;
  localparam int MP_S  = 2;
  localparam int MP_W  = 3;
  localparam longint MAXV = (longint'(1) <<< (PW-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (PW-1));

  typedef struct {
    logic [PW-1:0] p;
    logic          o;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RSTN;
  logic             start, abort, pre_en, pre_sub, in_valid, out_ready;
  logic [LEN_W-1:0] len;
  logic [PW-1:0]    c_init;
  logic [AW-1:0]    a_in;
  logic [BW-1:0]    b_in, d_in;

  logic             in_ready_s, out_valid_s, ovf_s, busy_s;
  logic             in_ready_w, out_valid_w, ovf_w, busy_w;
  logic [PW-1:0]    p_out_s, p_out_w;

  exp_t          exp_s[$], exp_w[$];
  int            sa[$], sb[$], sd[$];
  int            vectors = 0;
  int            miscompares = 0;
  bit            rnd_ready = 1'b0;
  logic [PW-1:0] last_p_s, last_p_w;

  always #5 CLK = ~CLK;

  dsp_mac_engine #(.AW(AW), .BW(BW), .PW(PW), .MPIPE(MP_S), .LEN_W(LEN_W), .SATURATE(1)) dut_sat (
    .CLK(CLK), .RSTN(RSTN), .start(start), .abort(abort), .len(len),
    .pre_en(pre_en), .pre_sub(pre_sub), .c_init(c_init),
    .in_valid(in_valid), .in_ready(in_ready_s),
    .a_in(a_in), .b_in(b_in), .d_in(d_in),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .p_out(p_out_s), .ovf(ovf_s), .busy(busy_s)
  );

  dsp_mac_engine #(.AW(AW), .BW(BW), .PW(PW), .MPIPE(MP_W), .LEN_W(LEN_W), .SATURATE(0)) dut_wrap (
    .CLK(CLK), .RSTN(RSTN), .start(start), .abort(abort), .len(len),
    .pre_en(pre_en), .pre_sub(pre_sub), .c_init(c_init),
    .in_valid(in_valid), .in_ready(in_ready_w),
    .a_in(a_in), .b_in(b_in), .d_in(d_in),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .p_out(p_out_w), .ovf(ovf_w), .busy(busy_w)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Dot product from the sample lists with exact 64-bit arithmetic, then
  // clamp or fold back into the PW-bit range after each sample.
  function automatic exp_t model(input longint ci, input bit pe, input bit ps, input bit sat);
    exp_t   r;
    longint acc, pre, s;
    acc = ci;
    r.o = 1'b0;
    foreach (sa[i]) begin
      pre = pe ? (ps ? longint'(sd[i]) - sb[i] : longint'(sd[i]) + sb[i]) : longint'(sb[i]);
      s   = acc + pre * sa[i];
      if (s > MAXV) begin
        r.o = 1'b1;
        acc = sat ? MAXV : s - (longint'(1) <<< PW);
      end else if (s < MINV) begin
        r.o = 1'b1;
        acc = sat ? MINV : s + (longint'(1) <<< PW);
      end else begin
        acc = s;
      end
    end
    r.p = acc[PW-1:0];
    return r;
  endfunction

  function automatic int rnd_op();
    return int'($urandom_range(0, (1 << AW) - 1)) - (1 << (AW-1));
  endfunction

  // Monitor: every cycle a result is presented it must match the head of the queue.
  always @(negedge CLK) begin
    if (out_valid_s) begin
      if (exp_s.size() == 0) check("sat_spurious_valid", out_valid_s, 1'b0);
      else begin
        check("sat_p_out", p_out_s, exp_s[0].p);
        check("sat_ovf", ovf_s, exp_s[0].o);
        if (out_ready) void'(exp_s.pop_front());
      end
    end
    if (out_valid_w) begin
      if (exp_w.size() == 0) check("wrap_spurious_valid", out_valid_w, 1'b0);
      else begin
        check("wrap_p_out", p_out_w, exp_w[0].p);
        check("wrap_ovf", ovf_w, exp_w[0].o);
        if (out_ready) void'(exp_w.pop_front());
      end
    end
  end

  always @(posedge CLK) begin
    if (rnd_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((busy_s || busy_w) && i < 300) begin
      tick();
      i++;
    end
    check("idle_wait", {busy_s, busy_w}, 2'b00);
  endtask

  task automatic set_sample(input int i);
    int v;
    v = sa[i]; a_in = v[AW-1:0];
    v = sb[i]; b_in = v[BW-1:0];
    v = sd[i]; d_in = v[BW-1:0];
  endtask

  task automatic start_job(input int n, input longint ci, input bit pe, input bit ps, input bit expect_out);
    exp_t e;
    if (expect_out) begin
      e = model(ci, pe, ps, 1'b1); exp_s.push_back(e); last_p_s = e.p;
      e = model(ci, pe, ps, 1'b0); exp_w.push_back(e); last_p_w = e.p;
    end
    len     = LEN_W'(n);
    c_init  = ci[PW-1:0];
    pre_en  = pe;
    pre_sub = ps;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic feed(input int from, input int to, input int gap_max, input bit inject);
    for (int i = from; i < to; i++) begin
      repeat ($urandom_range(0, gap_max)) tick();
      if (inject && i == from + 1) begin
        start = 1'b1; len = LEN_W'(1); c_init = '0; pre_en = ~pre_en;
        tick();
        start = 1'b0;
      end
      set_sample(i);
      in_valid = 1'b1;
      check("in_ready_run_s", in_ready_s, 1'b1);
      check("in_ready_run_w", in_ready_w, 1'b1);
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic run_job(input int n, input longint ci, input bit pe, input bit ps,
                         input int gap_max, input bit inject);
    wait_idle();
    start_job(n, ci, pe, ps, 1'b1);
    feed(0, n, gap_max, inject);
    check("in_ready_low", {in_ready_s, in_ready_w}, 2'b00);
  endtask

  // Called right after the final accept edge t with out_ready low: out_valid
  // must first appear at edge t+MPIPE+1, i.e. on negedge number MPIPE+2.
  task automatic check_latency();
    for (int k = 1; k <= MP_W + 2; k++) begin
      @(negedge CLK);
      check("latency_sat", out_valid_s, k >= MP_S + 2);
      check("latency_wrap", out_valid_w, k >= MP_W + 2);
    end
  endtask

  task automatic release_out(input int hold, input bit start_too);
    tick();
    repeat (hold) tick();
    out_ready = 1'b1;
    if (start_too) begin
      start = 1'b1; len = LEN_W'(3);
    end
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check("idle_after_handshake", {busy_s, busy_w, out_valid_s, out_valid_w}, 4'b0000);
  endtask

  initial begin
    int     n;
    longint ci;

    RSTN = 1'b0; start = 1'b0; abort = 1'b0; pre_en = 1'b0; pre_sub = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; len = '0; c_init = '0;
    a_in = '0; b_in = '0; d_in = '0;
    repeat (3) tick();
    check("reset_flags_sat", {in_ready_s, out_valid_s, busy_s, ovf_s}, 4'b0000);
    check("reset_flags_wrap", {in_ready_w, out_valid_w, busy_w, ovf_w}, 4'b0000);
    check("reset_p_sat", p_out_s, '0);
    check("reset_p_wrap", p_out_w, '0);
    RSTN = 1'b1;
    tick();

    // Plain MAC, back-to-back: 1*2+2*2+3*2+4*2 = 20.
    sa = {1, 2, 3, 4}; sb = {2, 2, 2, 2}; sd = {0, 0, 0, 0};
    run_job(4, 0, 1'b0, 1'b0, 0, 1'b0);
    check_latency();
    release_out(0, 1'b0);

    // Pre-adder subtract with initial value: 100 - 9 - 24 = 67.
    sa = {3, -4}; sb = {5, 1}; sd = {2, 7};
    run_job(2, 100, 1'b1, 1'b1, 0, 1'b0);
    check_latency();
    release_out(1, 1'b0);

    // Zero-length job: result is c_init one cycle after start, no samples taken.
    wait_idle();
    sa.delete(); sb.delete(); sd.delete();
    start_job(0, -5, 1'b0, 1'b0, 1'b1);
    check("zero_len_valid", {out_valid_s, out_valid_w}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      check("zero_len_in_ready", {in_ready_s, in_ready_w}, 2'b00);
      tick();
    end
    release_out(0, 1'b0);

    // Positive and negative overflow: clamp on one instance, wrap on the other.
    sa = {100}; sb = {100}; sd = {0};
    run_job(1, MAXV - 9, 1'b0, 1'b0, 0, 1'b0);
    check_latency();
    release_out(0, 1'b0);
    sa = {100}; sb = {-100}; sd = {0};
    run_job(1, MINV + 5, 1'b0, 1'b0, 0, 1'b0);
    check_latency();
    release_out(0, 1'b0);

    // Gapped input, start pulsed in RUN, result held 10 cycles, start in the DONE handshake.
    sa = {5, -6, 7, -8, 9}; sb = {10, 20, 30, 40, 50}; sd = {1, 2, 3, 4, 5};
    run_job(5, 1234, 1'b1, 1'b0, 3, 1'b1);
    check_latency();
    release_out(10, 1'b1);

    // Abort after 2 of 4 samples: no result, last result kept, then a clean job.
    wait_idle();
    sa = {7, 8, 9, 10}; sb = {1, 1, 1, 1}; sd = {0, 0, 0, 0};
    start_job(4, 50, 1'b0, 1'b0, 1'b0);
    feed(0, 2, 0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {busy_s, busy_w, in_ready_s, in_ready_w, out_valid_s, out_valid_w}, 6'b0);
    check("abort_keeps_p_sat", p_out_s, last_p_s);
    check("abort_keeps_p_wrap", p_out_w, last_p_w);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("abort_no_out", {out_valid_s, out_valid_w}, 2'b00);
    end
    sa = {-3, 5, 6}; sb = {2, 2, 2}; sd = {1, 1, 1};
    run_job(3, -20, 1'b1, 1'b0, 0, 1'b0);
    check_latency();
    release_out(0, 1'b0);

    // Reset while draining: everything cleared on the next edge.
    wait_idle();
    sa = {11, 12, 13}; sb = {3, 3, 3}; sd = {0, 0, 0};
    start_job(3, 77, 1'b0, 1'b0, 1'b0);
    feed(0, 3, 0, 1'b0);
    RSTN = 1'b0;
    tick();
    check("drain_reset_flags", {in_ready_s, out_valid_s, busy_s, ovf_s,
                                in_ready_w, out_valid_w, busy_w, ovf_w}, 8'b0);
    check("drain_reset_p_sat", p_out_s, '0);
    check("drain_reset_p_wrap", p_out_w, '0);
    RSTN = 1'b1;
    tick();

    // Random jobs with random gaps and random result back-pressure.
    rnd_ready = 1'b1;
    for (int j = 0; j < 40; j++) begin
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      case ($urandom_range(0, 2))
        0:       ci = MAXV - longint'($urandom_range(0, 1 << 20));
        1:       ci = MINV + longint'($urandom_range(0, 1 << 20));
        default: ci = longint'($urandom_range(0, 2000)) - 1000;
      endcase
      sa.delete(); sb.delete(); sd.delete();
      for (int i = 0; i < n; i++) begin
        sa.push_back(rnd_op());
        sb.push_back(rnd_op());
        sd.push_back(rnd_op());
      end
      run_job(n, ci, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), 1'b0);
    end
    wait_idle();
    rnd_ready = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;

    check("sat_results_pending", exp_s.size(), 0);
    check("wrap_results_pending", exp_w.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dsp_mac_engine.md
Name: dsp_mac_engine

Overview:
- Parametrised, pipelined multiply-accumulate engine; successor to the single-slice DSP datapath.
- The datapath is: pre-adder (D ± B), then signed multiplier (× A), then a configurable-depth pipeline, then a saturating or wrapping accumulator.
- A job controller runs an N-sample dot product. Samples enter on a valid/ready handshake and the result leaves on a second valid/ready handshake.
- Sits between sample-streaming front ends and downstream filter/accumulate stages.

Parameters:
- AW, 18, A operand width (signed).
- BW, 18, B and D operand width (signed).
- PW, 48, accumulator/result width (signed); must be ≥ AW+BW+1.
- MPIPE, 2, pipeline register stages from input accept to accumulator input, range 1..4.
- LEN_W, 8, width of the job length field.
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- CLK, in, 1, single clock, rising edge.
- RSTN, in, 1, reset: synchronous, active-low; clears all state.
- start, in, 1, job start pulse; sampled only in IDLE.
- abort, in, 1, synchronous flush to IDLE; ignored in IDLE.
- len, in, LEN_W, number of samples in the job; captured on start.
- pre_en, in, 1, 1 = multiplier operand is D ± B, 0 = B; captured on start.
- pre_sub, in, 1, 1 = D − B, 0 = D + B; captured on start.
- c_init, in, PW, accumulator initial value; captured on start.
- in_valid, in, 1, sample valid.
- in_ready, out, 1, engine accepts a sample this cycle.
- a_in, in, AW, A sample.
- b_in, in, BW, B sample.
- d_in, in, BW, D sample.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts the result.
- p_out, out, PW, accumulated result.
- ovf, out, 1, sticky overflow flag for the job; valid with out_valid.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset (RSTN=0 at a rising edge):
  - state = IDLE.
  - in_ready, out_valid, busy, ovf = 0; p_out = 0.
  - Pipeline valid bits and counters = 0.
  - Reset mid-job discards the job with no output.
- Arithmetic:
  - pre = pre_en ? (pre_sub ? d−b : d+b) : b. Computed at BW+1 bits, sign-extended, so the pre-adder never wraps.
  - m = pre × a, signed, AW+BW+1 bits, sign-extended to PW.
  - acc_next = acc + m, evaluated at PW+1 bits.
  - Overflow means the top two bits of the PW+1-bit sum differ.
  - SATURATE=1 clamps to +(2^(PW−1)−1) or −2^(PW−1). SATURATE=0 keeps the low PW bits.
  - Any overflow sets ovf, which stays set until the next start.
- IDLE:
  - in_ready=0.
  - start with len≠0: capture config, acc=c_init, ovf=0, remaining=len, next state RUN.
  - start with len=0: acc=c_init, ovf=0, next state DONE.
- RUN:
  - in_ready=1.
  - Each in_valid&&in_ready pushes a sample into stage 1 and decrements remaining.
  - When the accept that takes remaining 1→0 occurs, in_ready drops the next cycle and the state moves to DRAIN.
  - Cycles with in_valid=0 insert bubbles; the valid bit travels with the data.
- Pipeline and accumulator:
  - The accumulator updates only when the tail valid bit (stage MPIPE) is 1.
  - Latency: last accept at edge t leaves the last product at the tail at edge t+MPIPE−1, and it is accumulated at edge t+MPIPE.
- DRAIN: in_ready=0. When all pipeline valid bits are 0 and the final accumulate is done, go to DONE.
- DONE:
  - out_valid=1, with p_out=acc and ovf held stable.
  - out_valid&&out_ready: next state IDLE, out_valid=0 next cycle.
  - out_ready low holds the result indefinitely.
- Timing: out_valid rises at edge t+MPIPE+1 after the final accept at edge t.
- Start/abort interaction:
  - start outside IDLE is ignored; no queuing.
  - start in the same cycle as the DONE handshake is ignored, because the state is not yet IDLE.
- Abort (outside IDLE) at edge e:
  - state = IDLE; pipeline valid bits cleared; out_valid=0; p_out/ovf keep their last values.
  - Abort has priority over start, over both handshakes and over the accumulate.
- p_out updates only on transition into DONE.

Test Plan:
- MAC, pre-adder off: MPIPE=2, len=4, c_init=0, a=1,2,3,4, b=2, back-to-back -> out_valid 3 cycles after the 4th accept; p_out=20, ovf=0.
- Pre-adder subtract with init: pre_en=1, pre_sub=1, len=2, c_init=100, (a,b,d)=(3,5,2),(−4,1,7) -> p_out = 100 + (−9) + (−24) = 67.
- Zero-length job: len=0, c_init=−5 -> out_valid 1 cycle after start; p_out=−5, in_ready never asserts.
- Saturation: PW=40, SATURATE=1, c_init=2^39−10, len=1, a=b=100 -> p_out=2^39−1, ovf=1. Same stimulus with SATURATE=0 -> p_out wraps to −2^39+9990, ovf=1.
- Handshake stress: len=5 with in_valid gaps, then out_ready held low 10 cycles -> out_valid and p_out stable throughout. A start pulsed during RUN and during DONE is ignored. Result matches the gapless sum.
- Abort and reset: abort mid-RUN after 2 of 4 samples -> IDLE next cycle, no out_valid; a new job then returns the correct sum with no residue. RSTN=0 in DRAIN -> all outputs 0 next cycle.
